// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencing controller: FSM encoding,
// ALU function codes and display page selectors.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    HOLD  = 2'b11
  } state_t;

  localparam logic [1:0] FN_ADD = 2'b00;
  localparam logic [1:0] FN_SUB = 2'b01;
  localparam logic [1:0] FN_MUL = 2'b10;
  localparam logic [1:0] FN_DIV = 2'b11;

  localparam logic PG_RESULT   = 1'b0;
  localparam logic PG_OPERANDS = 1'b1;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Handshake bus between the sequencing controller (master) and the shared
// ALU datapath (slave).
interface alu_seq_ctrl_if #(parameter int width = 6);
  logic [width-1:0]   alu_a;
  logic [width-1:0]   alu_b;
  logic [1:0]         alu_func;
  logic               alu_start;
  logic               alu_done;
  logic [2*width-1:0] alu_out;
  logic               alu_ovf;

  modport master (
    output alu_a, alu_b, alu_func, alu_start,
    input  alu_done, alu_out, alu_ovf
  );

  modport slave (
    input  alu_a, alu_b, alu_func, alu_start,
    output alu_done, alu_out, alu_ovf
  );
endinterface

// File: rtl/alu_seq_ctrl_page_timer.sv
// Display page toggler for HOLD: flips page every PAGE_TICKS enabled cycles,
// restarting from the result page whenever clear is high.
module page_timer
  import alu_ctrl_pkg::*;
#(
  parameter int PAGE_TICKS = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic page
);

  // One spare bit so PAGE_TICKS = 2^k never wraps the counter early.
  localparam int CW = $clog2(PAGE_TICKS) + 1;
  localparam logic [CW-1:0] LAST = CW'(PAGE_TICKS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      page <= PG_RESULT;
    end else if (clear) begin
      cnt  <= '0;
      page <= PG_RESULT;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        page <= ~page;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequences one ALU operation per go pulse: latch operands, pulse start,
// wait for done with timeout, capture result, then page the display in HOLD.
//   state | meaning
//   IDLE  | no result yet / divide-by-zero flagged for next cycle
//   ISSUE | alu_start high for one cycle
//   WAIT  | counting towards TIMEOUT for alu_done
//   HOLD  | result valid, display paging
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int width      = 6,
  parameter int PAGE_TICKS = 50000000,
  parameter int TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [width-1:0]   a,
  input  logic [width-1:0]   b,
  input  logic [1:0]         func,
  output logic               busy,
  alu_seq_ctrl_if.master     alu_bus,
  output logic [2*width-1:0] result,
  output logic               err,
  output logic               timeout,
  output logic               valid,
  output logic               page
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT);

  state_t           state, state_n;
  logic [TW-1:0]    wait_cnt;
  logic             dz_pend;
  logic [width-1:0] a_q, b_q;
  logic [1:0]       func_q;
  logic             start_q;
  logic             accept, div_zero, pg_clear;

  // A flagged divide-by-zero occupies one IDLE cycle; go is not taken then.
  assign accept   = go && (state == IDLE || state == HOLD) && !dz_pend;
  assign div_zero = (func == FN_DIV) && (b == '0);
  assign pg_clear = accept || (state != HOLD);

  assign alu_bus.alu_a     = a_q;
  assign alu_bus.alu_b     = b_q;
  assign alu_bus.alu_func  = func_q;
  assign alu_bus.alu_start = start_q;

  always_comb begin
    state_n = state;
    case (state)
      IDLE, HOLD: begin
        if (accept)       state_n = div_zero ? IDLE : ISSUE;
        else if (dz_pend) state_n = HOLD;
      end
      ISSUE:   state_n = alu_bus.alu_done ? HOLD : WAIT;
      WAIT:    if (alu_bus.alu_done || wait_cnt == TO_VAL) state_n = HOLD;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      start_q  <= 1'b0;
      dz_pend  <= 1'b0;
      wait_cnt <= '0;
      a_q      <= '0;
      b_q      <= '0;
      func_q   <= '0;
      result   <= '0;
      err      <= 1'b0;
      timeout  <= 1'b0;
      valid    <= 1'b0;
    end else begin
      state   <= state_n;
      busy    <= (state_n == ISSUE) || (state_n == WAIT);
      start_q <= (state_n == ISSUE);
      dz_pend <= accept && div_zero;
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        func_q  <= func;
        valid   <= 1'b0;
        err     <= 1'b0;
        timeout <= 1'b0;
      end
      if (dz_pend) begin
        result  <= '0;
        err     <= 1'b1;
        timeout <= 1'b0;
        valid   <= 1'b1;
      end
      case (state)
        ISSUE: begin
          wait_cnt <= TW'(1);
          if (alu_bus.alu_done) begin
            result <= alu_bus.alu_out;
            err    <= alu_bus.alu_ovf;
            valid  <= 1'b1;
          end
        end
        WAIT: begin
          if (alu_bus.alu_done) begin
            result <= alu_bus.alu_out;
            err    <= alu_bus.alu_ovf;
            valid  <= 1'b1;
          end else if (wait_cnt == TO_VAL) begin
            result  <= '0;
            err     <= 1'b1;
            timeout <= 1'b1;
            valid   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: wait_cnt <= '0;
      endcase
    end
  end

  page_timer #(.PAGE_TICKS(PAGE_TICKS)) u_page_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (pg_clear),
    .en    (state == HOLD),
    .page  (page)
  );

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a hand-driven ALU model.
module tb_alu_seq_ctrl;
  import alu_ctrl_pkg::*;

  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           go = 1'b0;
  logic [W-1:0]   a = '0, b = '0;
  logic [1:0]     func = '0;
  logic           busy, err, timeout, valid, page;
  logic [2*W-1:0] result;
  logic           zl_mode = 1'b0, done_drv = 1'b0, ovf_drv = 1'b0;
  logic [2*W-1:0] out_drv = '0;
  int             checks = 0, failures = 0, start_cnt = 0, busy_cycles = 0;
  logic           page_exp [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  alu_seq_ctrl_if #(.width(W)) alu_bus ();

  assign alu_bus.alu_done = zl_mode ? alu_bus.alu_start : done_drv;
  assign alu_bus.alu_out  = out_drv;
  assign alu_bus.alu_ovf  = ovf_drv;

  alu_seq_ctrl #(.width(W), .PAGE_TICKS(3), .TIMEOUT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .go      (go),
    .a       (a),
    .b       (b),
    .func    (func),
    .busy    (busy),
    .alu_bus (alu_bus),
    .result  (result),
    .err     (err),
    .timeout (timeout),
    .valid   (valid),
    .page    (page)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (alu_bus.alu_start) start_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick; tick;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_start", 32'(alu_bus.alu_start), 0);
    chk("rst_page", 32'(page), 0);
    rst = 1'b0;
    tick;

    // add with 3-cycle ALU
    a = 6'd5; b = 6'd3; func = FN_ADD; out_drv = 12'd8; go = 1'b1;
    tick;
    go = 1'b0;
    chk("add_alu_a", 32'(alu_bus.alu_a), 5);
    chk("add_alu_b", 32'(alu_bus.alu_b), 3);
    chk("add_func", 32'(alu_bus.alu_func), 0);
    for (int i = 0; i < 4; i++) begin
      if (busy) busy_cycles++;
      if (i == 0) chk("add_start_hi", 32'(alu_bus.alu_start), 1);
      if (i == 1) chk("add_start_lo", 32'(alu_bus.alu_start), 0);
      chk("add_valid_lo", 32'(valid), 0);
      if (i == 3) done_drv = 1'b1;
      tick;
    end
    done_drv = 1'b0;
    chk("add_busy_cycles", 32'(busy_cycles), 4);
    chk("add_busy_off", 32'(busy), 0);
    chk("add_result", 32'(result), 8);
    chk("add_err", 32'(err), 0);
    chk("add_valid", 32'(valid), 1);

    // page sequence in HOLD
    for (int i = 0; i < 7; i++) begin
      chk("page_seq", 32'(page), 32'(page_exp[i]));
      tick;
    end
    tick; tick;
    chk("page_mid", 32'(page), 1);

    // go mid-page, ALU never answers -> timeout; switches move during busy
    a = 6'd1; b = 6'd1; func = FN_SUB; out_drv = 12'h555; go = 1'b1;
    tick;
    go = 1'b0; a = 6'h2A;
    chk("to_page_clr", 32'(page), 0);
    chk("to_valid_clr", 32'(valid), 0);
    chk("to_busy", 32'(busy), 1);
    tick; tick; tick; tick;
    chk("to_still_busy", 32'(busy), 1);
    chk("to_not_valid", 32'(valid), 0);
    chk("to_alu_a_stable", 32'(alu_bus.alu_a), 1);
    tick;
    chk("to_valid", 32'(valid), 1);
    chk("to_err", 32'(err), 1);
    chk("to_timeout", 32'(timeout), 1);
    chk("to_result", 32'(result), 0);
    chk("to_busy_off", 32'(busy), 0);

    // divide by zero from HOLD
    a = 6'd13; b = 6'd0; func = FN_DIV; go = 1'b1;
    tick;
    go = 1'b0;
    chk("dz_valid_clr", 32'(valid), 0);
    chk("dz_start", 32'(alu_bus.alu_start), 0);
    chk("dz_busy", 32'(busy), 0);
    chk("dz_alu_a", 32'(alu_bus.alu_a), 13);
    tick;
    chk("dz_result", 32'(result), 0);
    chk("dz_err", 32'(err), 1);
    chk("dz_timeout", 32'(timeout), 0);
    chk("dz_valid", 32'(valid), 1);
    tick; tick;
    chk("dz_page_restart0", 32'(page), 0);
    tick;
    chk("dz_page_restart1", 32'(page), 1);
    chk("dz_no_start", 32'(start_cnt), 2);

    // zero-latency mul, go held into busy
    zl_mode = 1'b1; out_drv = 12'hFFA; ovf_drv = 1'b0;
    a = 6'h3E; b = 6'd3; func = FN_MUL; go = 1'b1;
    tick;
    chk("mul_start", 32'(alu_bus.alu_start), 1);
    chk("mul_busy", 32'(busy), 1);
    tick;
    go = 1'b0;
    chk("mul_result", 32'(result), 32'h0FFA);
    chk("mul_valid", 32'(valid), 1);
    chk("mul_err", 32'(err), 0);
    tick;
    chk("mul_one_start", 32'(start_cnt), 3);
    chk("mul_busy_off", 32'(busy), 0);

    // overflow reported through err
    out_drv = 12'h040; ovf_drv = 1'b1; a = 6'd31; b = 6'd31; func = FN_ADD; go = 1'b1;
    tick;
    go = 1'b0;
    tick;
    chk("ovf_err", 32'(err), 1);
    chk("ovf_result", 32'(result), 32'h040);
    ovf_drv = 1'b0;

    // async reset mid-WAIT
    zl_mode = 1'b0; done_drv = 1'b0;
    a = 6'd2; b = 6'd2; func = FN_ADD; go = 1'b1;
    tick;
    go = 1'b0;
    tick;
    chk("pre_rst_busy", 32'(busy), 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_valid", 32'(valid), 0);
    chk("arst_result", 32'(result), 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_alu_a", 32'(alu_bus.alu_a), 0);
    chk("arst_start", 32'(alu_bus.alu_start), 0);
    zl_mode = 1'b1; out_drv = 12'd3; a = 6'd7; b = 6'd4; func = FN_SUB; go = 1'b1;
    #1 rst = 1'b0;
    tick;
    go = 1'b0;
    chk("post_rst_start", 32'(alu_bus.alu_start), 1);
    tick;
    chk("post_rst_result", 32'(result), 3);
    chk("post_rst_valid", 32'(valid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencing controller between the operand switches/keys and the shared ALU datapath (add/sub/mul/div, 2-bit func).
- Accepts one operation request per go pulse and latches operands.
- Issues a start pulse to the ALU, waits for done with a timeout, and captures result and overflow into registers.
- In HOLD it alternates the display page between result and operands, driving the out_sel input of the display mux.

Parameters:
- width, 6, operand width; result is 2*width.
- PAGE_TICKS, 50000000, cycles per display page in HOLD; legal range is 1 or more.
- TIMEOUT, 64, max cycles from alu_start to alu_done before aborting; legal range is 1 or more.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- go  in  1  single-cycle request pulse, already debounced.
- a  in  width  operand A (two's complement).
- b  in  width  operand B (two's complement).
- func  in  2  op select: 00 add, 01 sub, 10 mul, 11 div.
- busy  out  1  high in ISSUE/WAIT.
- alu_a  out  width  latched operand A to the ALU.
- alu_b  out  width  latched operand B to the ALU.
- alu_func  out  2  latched op to the ALU.
- alu_start  out  1  one-cycle start pulse.
- alu_done  in  1  ALU result valid, sampled on clk.
- alu_out  in  2*width  ALU result; for div, {quotient, remainder}.
- alu_ovf  in  1  ALU overflow, valid with alu_done.
- result  out  2*width  captured result.
- err  out  1  overflow, divide-by-zero or timeout.
- timeout  out  1  the last operation aborted on timeout.
- valid  out  1  result/err reflect a completed operation.
- page  out  1  display page: 0 shows result, 1 shows operands.

Behaviour:
- Reset (async; rst high forces these immediately, including mid-operation):
  - state = IDLE.
  - All outputs 0.
  - Page and wait counters 0.
  - alu_start deasserts at once.
- States: IDLE, ISSUE, WAIT, HOLD. Encoding is defined in the package.
- IDLE or HOLD, go=1 at edge N:
  - a/b/func latch into alu_a/alu_b/alu_func.
  - valid, err, timeout clear.
  - page = 0.
  - State goes to ISSUE; busy=1 from N+1.
- Divide-by-zero check (func==11 and b==0 at edge N):
  - No ISSUE.
  - At edge N+1: result=0, err=1, timeout=0, valid=1, state HOLD.
  - alu_start is never asserted.
- ISSUE (one cycle):
  - alu_start=1 for exactly this cycle.
  - If alu_done=1 in this cycle, capture it (zero-latency ALU) and go to HOLD; otherwise go to WAIT.
  - The wait counter starts at 1.
- WAIT:
  - alu_done=1: result<=alu_out, err<=alu_ovf, valid<=1, go to HOLD.
  - Otherwise the counter increments.
  - Counter==TIMEOUT with no done: result<=0, err<=1, timeout<=1, valid<=1, go to HOLD.
  - alu_done takes priority over timeout in the same cycle.
- alu_a/alu_b/alu_func hold stable from latch until the next accepted go; input switch changes during busy are ignored.
- go while busy is ignored and not queued.
- HOLD:
  - The page counter counts 0..PAGE_TICKS-1; on wrap, page toggles.
  - With PAGE_TICKS=1, page toggles every cycle.
  - go in HOLD restarts as in IDLE; the page counter resets to 0 and page=0.
- alu_done outside ISSUE/WAIT is ignored.
- Latency: go to alu_start is 1 cycle; alu_done (in WAIT) to valid is 1 cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Counter widths are $clog2 of the parameter plus 1; the page counter must not overflow at PAGE_TICKS=2^k.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - the state encoding (IDLE, ISSUE, WAIT, HOLD);
  - the func constants FN_ADD=00, FN_SUB=01, FN_MUL=10, FN_DIV=11;
  - the page constants PG_RESULT=0, PG_OPERANDS=1.
- One sub-module, page_timer:
  - parameter PAGE_TICKS; inputs clk, rst, clear, en; output page;
  - holds the HOLD-state toggle counter.

Test Plan:
- ALU model with 3-cycle done; go with a=5, b=3, func=00 -> alu_start 1 cycle after go; result=8, err=0, valid=1 one cycle after done; busy high 4 cycles.
- func=11, a=13, b=0, go -> no alu_start ever; next cycle result=0, err=1, timeout=0, valid=1.
- ALU never asserts done, TIMEOUT=4 -> HOLD after 4 WAIT-counted cycles; err=1, timeout=1, result=0.
- Zero-latency ALU (done with start); mul a=-2, b=3 -> result=12'hFFA two cycles after go; go pulses during busy produce no second alu_start.
- PAGE_TICKS=3 in HOLD -> page sequence 0,0,0,1,1,1,0...; go mid-page -> page=0 and counter restarts.
- rst pulse asserted mid-WAIT (between edges) -> all outputs 0 immediately; state IDLE; a subsequent go runs normally.
